// File: rtl/byte_serial_adder.sv
// Adds two NBYTES-wide operands one byte per clock through an external 8-bit adder.
// Optional feature macro BSA_OVERFLOW_EN adds the registered signed-overflow output Ovf.
module byte_serial_adder #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   A,
  input  logic [8*NBYTES-1:0]   B,
  input  logic                  Cin,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   Sum,
  output logic                  Cout
`ifdef BSA_OVERFLOW_EN
  ,
  output logic                  Ovf
`endif
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = $clog2(NBYTES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            cin_q, cin_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic [IDXW+2:0] bit_ofs;
`ifdef BSA_OVERFLOW_EN
  logic            ovf_q, ovf_d;
`endif

  assign bit_ofs   = {idx_q, 3'b000};
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Sum       = sum_q;
  assign Cout      = cout_q;
`ifdef BSA_OVERFLOW_EN
  assign Ovf       = ovf_q;
`endif

  // Next-state, byte datapath and adder drive.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef BSA_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    add_a   = 8'h00;
    add_b   = 8'h00;
    add_cin = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          cin_d   = Cin;
          idx_d   = {IDXW{1'b0}};
          carry_d = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        add_a   = 8'(a_q >> bit_ofs);
        add_b   = 8'(b_q >> bit_ofs);
        add_cin = (idx_q == {IDXW{1'b0}}) ? cin_q : carry_q;
        sum_d   = (sum_q & ~(W'(8'hFF) << bit_ofs)) | (W'(add_sum) << bit_ofs);
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
`ifdef BSA_OVERFLOW_EN
          // carry into the MSB recovered from the top byte's bit 7
          ovf_d   = add_a[7] ^ add_b[7] ^ add_sum[7] ^ add_cout;
`endif
          idx_d   = {IDXW{1'b0}};
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      sum_q   <= {W{1'b0}};
      idx_q   <= {IDXW{1'b0}};
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef BSA_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef BSA_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_byte_serial_adder.sv
// Self-checking bench for byte_serial_adder (NBYTES=4) with an arithmetic reference model.
module tb_byte_serial_adder;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, Cin, add_cin, add_cout;
  logic        out_valid, out_ready, Cout;
  logic [31:0] A, B, Sum;
  logic [7:0]  add_a, add_b, add_sum;
`ifdef BSA_OVERFLOW_EN
  logic        Ovf;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  // External 8-bit adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  byte_serial_adder #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Cout(Cout)
`ifdef BSA_OVERFLOW_EN
    , .Ovf(Ovf)
`endif
  );

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
  endtask

  // Reference model: operation latency and results from plain arithmetic
  logic        started = 1'b0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_a = '0, m_b = '0, m_sum = '0;
  logic        m_cin = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
  logic [32:0] m_res = '0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      started = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
      m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (m_busy) begin
      m_cnt++;
      if (m_cnt == NB) begin
        m_busy = 1'b0; m_done = 1'b1;
        m_sum  = m_res[31:0];
        m_cout = m_res[32];
        m_ovf  = m_res[32] ^ (((m_a & 32'h7FFFFFFF) + (m_b & 32'h7FFFFFFF) + {31'd0, m_cin}) >> 31);
      end
    end else if (in_valid) begin
      m_busy = 1'b1; m_cnt = 0;
      m_a = A; m_b = B; m_cin = Cin;
      m_res = {1'b0, A} + {1'b0, B} + {32'd0, Cin};
    end
  end

  // Per-cycle comparison of every meaningful output against the model
  always @(negedge clk) begin
    logic [63:0] mask, part;
    if (started) begin
      check("in_ready", in_ready, !(m_busy || m_done));
      check("out_valid", out_valid, m_done);
      if (m_busy) begin
        mask = (64'd1 << (8 * m_cnt)) - 64'd1;
        part = ({32'd0, m_a} & mask) + ({32'd0, m_b} & mask) + {63'd0, m_cin};
        check("add_a", add_a, ({32'd0, m_a} >> (8 * m_cnt)) & 64'hFF);
        check("add_b", add_b, ({32'd0, m_b} >> (8 * m_cnt)) & 64'hFF);
        check("add_cin", add_cin, (part >> (8 * m_cnt)) & 64'd1);
      end else begin
        check("add_idle", {add_a, add_b, add_cin}, 17'd0);
        check("Sum", Sum, m_sum);
        check("Cout", Cout, m_cout);
`ifdef BSA_OVERFLOW_EN
        check("Ovf", Ovf, m_ovf);
`endif
      end
    end
  end

  // One operation; caller is positioned just after a clock edge with the block idle
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic [31:0] es, input logic ec, input logic eo, input int hold);
    int lat;
    A = a; B = b; Cin = c; in_valid = 1'b1; out_ready = 1'b0;
    check("accept_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    if (hold > 0) begin A = ~a; B = ~b; end
    else in_valid = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 20);
    check("latency", lat, NB);
    check("lit_sum", Sum, es);
    check("lit_cout", Cout, ec);
`ifdef BSA_OVERFLOW_EN
    check("lit_ovf", Ovf, eo);
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_sum", Sum, es);
      check("hold_cout", Cout, ec);
      check("hold_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", out_valid, 1'b0);
    check("release_ready", in_ready, 1'b1);
  endtask

  logic [31:0] ba[4] = '{32'h00000001, 32'hDEADBEEF, 32'hFFFF0000, 32'h00FF00FF};
  logic [31:0] bb[4] = '{32'h00000002, 32'h01020304, 32'h0000FFFF, 32'hFF00FF00};
  logic        bc[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] bs[4] = '{32'h00000003, 32'hDFAFC1F4, 32'h00000000, 32'hFFFFFFFF};
  logic        bo[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int lat, prev;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    check("rst_ready", in_ready, 1'b1);
    check("rst_valid", out_valid, 1'b0);
    check("rst_sum", Sum, 32'h0);
    check("rst_cout", Cout, 1'b0);

    do_op(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 0);
    do_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 0);
    do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 0);
    do_op(32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0, 1'b0, 5);

    // Reset in the middle of RUN, at byte index 2
    A = 32'hA5A5A5A5; B = 32'h5A5A5A5A; Cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_ready", in_ready, 1'b1);
    check("midrst_sum", Sum, 32'h0);
    do_op(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 0);

    // Back-to-back with in_valid and out_ready held high
    A = ba[0]; B = bb[0]; Cin = bc[0]; in_valid = 1'b1; out_ready = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 20);
      check("b2b_valid", out_valid, 1'b1);
      check("b2b_sum", Sum, bs[k]);
      check("b2b_cout", Cout, bo[k]);
      if (k > 0) check("b2b_period", cyc - prev, 6);
      prev = cyc;
      if (k < 3) begin A = ba[k+1]; B = bb[k+1]; Cin = bc[k+1]; end
      else in_valid = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/byte_serial_adder.md
BYTE_SERIAL_ADDER -- requirements
Module: byte_serial_adder

Interface
REQ-001 The block SHALL have one parameter: NBYTES, default 4, giving the operand width in bytes (legal range 2..16).
REQ-002 The block SHALL have the port clk, input, 1 bit, the single rising-edge clock.
REQ-003 The block SHALL have the port rst, input, 1 bit, the reset, which is synchronous and active-high.
REQ-004 The block SHALL have the port in_valid, input, 1 bit, asserted when an operand set is offered.
REQ-005 The block SHALL have the port in_ready, output, 1 bit, asserted when the block can accept an operand set.
REQ-006 The block SHALL have the port A, input, 8*NBYTES bits, operand A.
REQ-007 The block SHALL have the port B, input, 8*NBYTES bits, operand B.
REQ-008 The block SHALL have the port Cin, input, 1 bit, the carry into byte 0.
REQ-009 The block SHALL have the ports add_a and add_b, output, 8 bits each, the operand bytes driven to the external 8-bit adder.
REQ-010 The block SHALL have the port add_cin, output, 1 bit, the carry driven to the external adder.
REQ-011 The block SHALL have the port add_sum, input, 8 bits, the combinational sum returned by the external adder.
REQ-012 The block SHALL have the port add_cout, input, 1 bit, the combinational carry returned by the external adder.
REQ-013 The block SHALL have the port out_valid, output, 1 bit, asserted when a result is held.
REQ-014 The block SHALL have the port out_ready, input, 1 bit, asserted when the consumer accepts the result.
REQ-015 The block SHALL have the port Sum, output, 8*NBYTES bits, the registered result.
REQ-016 The block SHALL have the port Cout, output, 1 bit, the registered final carry.

Function
REQ-017 The block SHALL use three states: IDLE, RUN and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-019 A transfer on the rising edge where in_valid=1 and in_ready=1 SHALL latch A, B and Cin, clear the byte index to 0, and move the block to RUN.
REQ-020 In RUN, byte index i SHALL drive add_a=A[8i+7:8i] and add_b=B[8i+7:8i]; add_cin SHALL be the latched Cin when i=0 and the registered add_cout of byte i-1 otherwise.
REQ-021 On each RUN edge, add_sum SHALL be written into Sum[8i+7:8i], add_cout SHALL be registered, and i SHALL increment.
REQ-022 After the edge that processes i=NBYTES-1, the final carry SHALL be written to Cout and the block SHALL move to DONE.
REQ-023 Latency SHALL be fixed: for an accept edge k, out_valid rises on edge k+NBYTES.
REQ-024 In DONE, Sum and Cout SHALL hold stable until an edge with out_ready=1, after which the block SHALL move to IDLE.
REQ-025 There SHALL be no overlap: at most one acceptance per NBYTES+2 cycles.
REQ-026 Outside RUN, add_a, add_b and add_cin SHALL be driven to 0.
REQ-027 in_valid asserted while the block is not in IDLE SHALL be ignored, with no side effects.
REQ-028 Arithmetic SHALL be unsigned modulo 2^(8*NBYTES), with Cout as bit 8*NBYTES of A+B+Cin.
REQ-029 In DONE, out_ready=1 together with in_valid=1 SHALL NOT accept new operands that cycle.

Reset
REQ-030 While rst=1 at a clock edge, the block SHALL enter IDLE and set Sum=0, Cout=0, out_valid=0, in_ready=1, index=0 and the carry register=0.
REQ-031 A reset asserted in RUN or DONE SHALL discard the in-flight operation, and no partial result SHALL become visible.
REQ-032 The first edge after rst deasserts SHALL be able to accept operands.

Configuration
REQ-033 When BSA_OVERFLOW_EN is defined, the block SHALL add an output port Ovf, 1 bit, registered with Cout, equal to the signed two's-complement overflow (carry into the MSB XOR carry out of the MSB); Ovf SHALL reset to 0.
REQ-034 When BSA_OVERFLOW_EN is not defined, the Ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (NBYTES=4, the bench models the adder as add_sum/add_cout = add_a+add_b+add_cin)
REQ-035 The bench SHALL drive A=0x000000FF, B=0x00000001, Cin=0 -> Sum=0x00000100, Cout=0, with out_valid on edge 4 after the accept.
REQ-036 The bench SHALL drive A=0xFFFFFFFF, B=0x00000000, Cin=1 -> Sum=0x00000000, Cout=1, with the carry rippling through all 4 bytes.
REQ-037 The bench SHALL drive A=0x7FFFFFFF, B=0x00000001, Cin=0 -> Sum=0x80000000, Cout=0, and Ovf=1 when BSA_OVERFLOW_EN is defined.
REQ-038 The bench SHALL hold out_ready=0 for 5 cycles in DONE -> Sum and Cout stable, and in_ready=0 with in_valid=1 ignored throughout.
REQ-039 The bench SHALL assert rst for 1 cycle during RUN at i=2 -> IDLE next edge, out_valid never asserted, Sum=0, and the next operation correct.
REQ-040 The bench SHALL run back-to-back operations with in_valid and out_ready held at 1 -> one result every 6 cycles, each correct.
